// File: rtl/kyber_coef_loader.sv
// kyber_coef_loader: reduces a natural-order coefficient stream mod q and writes it
// into the two-bank BRAM row layout (0,2),(1,3),(4,6),(5,7),...
module kyber_coef_loader #(
   parameter int Q  = 3329,
   parameter int N  = 256,
   parameter int DW = 12,
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          din_valid,
   input  logic [DW-1:0] din,
   output logic          din_ready,
   output logic          we0,
   output logic          we1,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] wdata,
   output logic          busy,
   output logic          done,
   output logic          range_err
);
   localparam int IW = $clog2(N);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   state_t        r_state;
   logic [IW-1:0] r_idx;
   logic          r_we0, r_we1, r_err;
   logic [AW-1:0] r_waddr;
   logic [DW-1:0] r_wdata;
   logic          w_acc, w_big;
   logic [DW-1:0] w_red;
   assign w_acc     = din_valid && r_state == LOAD;
   // a single subtraction is enough because the largest input is below 2q
   assign w_big     = din >= DW'(Q);
   assign w_red     = w_big ? din - DW'(Q) : din;
   assign din_ready = r_state == LOAD;
   assign busy      = r_state == LOAD;
   assign done      = r_state == DONE;
   assign we0       = r_we0;
   assign we1       = r_we1;
   assign waddr     = r_waddr;
   assign wdata     = r_wdata;
   assign range_err = r_err;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_we0   <= 1'b0;
         r_we1   <= 1'b0;
         r_err   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we0 <= 1'b0;
         r_we1 <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               r_state <= LOAD;
               r_idx   <= '0;
               r_err   <= 1'b0;
            end
            LOAD: if (w_acc) begin
               r_we0   <= ~r_idx[1];
               r_we1   <= r_idx[1];
               r_waddr <= {r_idx[IW-1:2], r_idx[0]};
               r_wdata <= w_red;
               r_idx   <= r_idx + 1'b1;
               if (w_big) r_err <= 1'b1;
               if (r_idx == IW'(N-1)) r_state <= DONE;
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_kyber_coef_loader.sv
// tb_kyber_coef_loader: randomized loads checked cycle by cycle against an
// index-arithmetic reference of the bank/row mapping and mod-q reduction.
module tb_kyber_coef_loader;
   logic        clk = 1'b0, reset = 1'b0, start = 1'b0, din_valid = 1'b0;
   logic [11:0] din = '0;
   logic        din_ready, we0, we1, busy, done, range_err;
   logic [6:0]  waddr;
   logic [11:0] wdata;
   int n_vec = 0, n_err = 0;
   int m_idx = 0, writes = 0, busy_cnt = 0, done_cnt = 0;
   bit m_load = 0, m_dn = 0, m_err = 0, e_we0 = 0, e_we1 = 0;
   int e_addr = 0, e_data = 0;

   kyber_coef_loader dut (
      .clk(clk), .reset(reset), .start(start), .din_valid(din_valid), .din(din),
      .din_ready(din_ready), .we0(we0), .we1(we1), .waddr(waddr), .wdata(wdata),
      .busy(busy), .done(done), .range_err(range_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("we0", 32'(we0), 32'(e_we0));
      chk("we1", 32'(we1), 32'(e_we1));
      chk("waddr", 32'(waddr), 32'(e_addr));
      chk("wdata", 32'(wdata), 32'(e_data));
      chk("done", 32'(done), 32'(m_dn));
      chk("range_err", 32'(range_err), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_load));
      chk("din_ready", 32'(din_ready), 32'(m_load));
   endtask

   task automatic drive(input bit st, input bit v, input int d);
      bit prev_dn = m_dn;
      int i = m_idx;
      start = st; din_valid = v; din = 12'(d);
      @(posedge clk); #1;
      e_we0 = 0; e_we1 = 0; m_dn = 0;
      if (m_load && v) begin
         e_we0 = ((i / 2) % 2) == 0;
         e_we1 = !e_we0;
         e_addr = (i / 4) * 2 + i % 2;
         e_data = d % 3329;
         if (d >= 3329) m_err = 1;
         m_idx++;
         writes++;
         if (m_idx == 256) begin m_load = 0; m_dn = 1; end
      end else if (!m_load && !prev_dn && st) begin
         m_load = 1; m_idx = 0; m_err = 0;
      end
      check_outputs();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
   endtask

   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      m_load = 0; m_dn = 0; m_idx = 0; m_err = 0;
      e_we0 = 0; e_we1 = 0; e_addr = 0; e_data = 0;
      check_outputs();
      #3 reset = 1'b0;
   endtask

   // mode 0: din=i, 1: random, 2: reduction boundaries then random
   task automatic run_load(input int mode, input bit bubbles, input bit stray, input int abort_at);
      int guard = 0;
      writes = 0; busy_cnt = 0; done_cnt = 0;
      drive(1, 1'($urandom % 2), int'($urandom_range(0, 4095)));
      chk("load_started", 32'(busy), 32'd1);
      while (m_load && guard < 3000) begin
         int d;
         bit v, st;
         guard++;
         if (m_idx == abort_at) begin
            async_reset();
            return;
         end
         d = mode == 0 ? m_idx : int'($urandom_range(0, 4095));
         if (mode == 2 && m_idx < 10) d = int'($urandom_range(0, 3328));
         if (mode == 2 && m_idx == 10) d = 3328;
         if (mode == 2 && m_idx == 11) d = 3329;
         if (mode == 2 && m_idx == 12) d = 4095;
         v = bubbles ? 1'($urandom % 2) : 1'b1;
         st = stray && (m_idx == 100 || m_idx == 255);
         if (st && m_idx == 255) v = 1'b1;
         drive(st, v, d);
      end
      chk("load_timeout", 32'(m_load), 32'd0);
      chk("write_count", 32'(writes), 32'd256);
      chk("done_count", 32'(done_cnt), 32'd1);
      if (!bubbles) chk("busy_cycles", 32'(busy_cnt), 32'd256);
      drive(stray, 1'b1, 5);
      drive(0, 1'b1, 7);
      chk("idle_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      @(posedge clk); #1;
      async_reset();
      repeat (3) drive(0, 1'($urandom % 2), int'($urandom_range(0, 4095)));
      run_load(0, 0, 0, -1);
      run_load(2, 0, 0, -1);
      run_load(1, 1, 0, -1);
      run_load(1, 1, 1, -1);
      run_load(1, 0, 0, 37);
      repeat (2) drive(0, 1'b1, 4000);
      run_load(1, 0, 0, -1);
      run_load(2, 1, 1, -1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
